// File: rtl/keyboard.sv
// PS/2 scan-code set 2 receiver that tracks held/released state of Up, Down, Left, Right and Space.
// Inputs are synchronized and glitch-filtered; frames are deframed, then E0/F0 prefixes steer the key map.
// Outputs are registered levels that change one cycle after the sampling event of a good stop bit.
module keyboard #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk_25MHz,
  input  logic rst,
  input  logic PS2Clk,
  input  logic PS2Data,
  output logic upKeyState,
  output logic downKeyState,
  output logic leftKeyState,
  output logic rightKeyState,
  output logic spaceKeyState
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  // Synchronizer and filter state; idle bus level is 1
  logic          clk_s1, clk_s2;
  logic          data_s1, data_s2;
  logic [FW-1:0] filt_cnt;
  logic          filt;
  logic          filt_d;
  logic          fall;

  // Receiver state
  rx_state_t     state, state_nxt;
  logic [2:0]    bit_idx, bit_nxt;
  logic [7:0]    shreg, sh_nxt;
  logic          par, par_nxt;
  logic [TW-1:0] tcnt, tcnt_nxt;
  logic          byte_vld;

  // Prefix flags
  logic          ext, brk;

  // Two-flop synchronizers on both raw PS/2 lines
  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= PS2Clk;
      clk_s2  <= clk_s1;
      data_s1 <= PS2Data;
      data_s2 <= data_s1;
    end
  end

  // Glitch filter: the filtered clock follows only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      filt_cnt <= '0;
      filt     <= 1'b1;
      filt_d   <= 1'b1;
    end else begin
      filt_d <= filt;
      if (clk_s2 == filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        filt     <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  // Sampling event: the cycle in which the filtered clock has just dropped
  assign fall = filt_d & ~filt;

  // Receiver state register
  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      state   <= RX_IDLE;
      bit_idx <= '0;
      shreg   <= '0;
      par     <= 1'b0;
      tcnt    <= '0;
    end else begin
      state   <= state_nxt;
      bit_idx <= bit_nxt;
      shreg   <= sh_nxt;
      par     <= par_nxt;
      tcnt    <= tcnt_nxt;
    end
  end

  // Receiver next-state: frame bit sequencing, mid-frame timeout and frame validation
  always_comb begin
    state_nxt = state;
    bit_nxt   = bit_idx;
    sh_nxt    = shreg;
    par_nxt   = par;
    tcnt_nxt  = tcnt;
    byte_vld  = 1'b0;

    // Idle-time counter only runs mid-frame; expiry abandons the partial frame
    if (state == RX_IDLE || fall) begin
      tcnt_nxt = '0;
    end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
      tcnt_nxt  = '0;
      state_nxt = RX_IDLE;
    end else begin
      tcnt_nxt = tcnt + TW'(1);
    end

    if (fall) begin
      case (state)
        RX_IDLE: begin
          // A 1 in the start position is not a frame; stay idle
          if (!data_s2) begin
            state_nxt = RX_DATA;
            bit_nxt   = '0;
          end
        end
        RX_DATA: begin
          sh_nxt  = {data_s2, shreg[7:1]};
          bit_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = RX_PARITY;
        end
        RX_PARITY: begin
          par_nxt   = data_s2;
          state_nxt = RX_STOP;
        end
        RX_STOP: begin
          // Odd parity over data+parity and a high stop bit make the byte good
          state_nxt = RX_IDLE;
          byte_vld  = data_s2 & (^{shreg, par});
        end
        default: state_nxt = RX_IDLE;
      endcase
    end
  end

  // Decoder: prefix bytes set sticky flags; any other byte acts on the key map and clears them
  always_ff @(posedge clk_25MHz or posedge rst) begin
    if (rst) begin
      ext           <= 1'b0;
      brk           <= 1'b0;
      upKeyState    <= 1'b0;
      downKeyState  <= 1'b0;
      leftKeyState  <= 1'b0;
      rightKeyState <= 1'b0;
      spaceKeyState <= 1'b0;
    end else if (byte_vld) begin
      if (shreg == 8'hE0) begin
        ext <= 1'b1;
      end else if (shreg == 8'hF0) begin
        brk <= 1'b1;
      end else begin
        ext <= 1'b0;
        brk <= 1'b0;
        if (ext) begin
          case (shreg)
            8'h75:   upKeyState    <= ~brk;
            8'h72:   downKeyState  <= ~brk;
            8'h6B:   leftKeyState  <= ~brk;
            8'h74:   rightKeyState <= ~brk;
            default: ;
          endcase
        end else if (shreg == 8'h29) begin
          spaceKeyState <= ~brk;
        end
      end
    end
  end

endmodule

// File: tb/tb_keyboard.sv
// Scoreboard bench for keyboard: stimulus pushes expected output changes and checkpoints,
// a negedge monitor pops and compares whenever the outputs change or a checkpoint is requested.
module tb_keyboard;

  localparam int HALF = 30;   // PS/2 half bit period in system cycles
  localparam int TMO  = 2000; // shortened timeout keeps the run short
  localparam int LAT  = 11;   // raw fall -> output: 2 sync + 8 filter + 1 register

  typedef struct {
    logic [4:0] vec;
    int         cyc;   // expected cycle of change, -1 when not timed
  } exp_t;

  logic clk_25MHz = 1'b0;
  logic rst       = 1'b0;
  logic PS2Clk    = 1'b1;
  logic PS2Data   = 1'b1;
  logic upKeyState, downKeyState, leftKeyState, rightKeyState, spaceKeyState;

  exp_t chg_q[$];
  exp_t chk_q[$];
  int   cyc     = 0;
  int   n_cmp   = 0;
  int   n_err   = 0;
  logic chk_req = 1'b0;
  logic mon_en  = 1'b0;

  keyboard #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_25MHz    (clk_25MHz),
    .rst          (rst),
    .PS2Clk       (PS2Clk),
    .PS2Data      (PS2Data),
    .upKeyState   (upKeyState),
    .downKeyState (downKeyState),
    .leftKeyState (leftKeyState),
    .rightKeyState(rightKeyState),
    .spaceKeyState(spaceKeyState)
  );

  always #20 clk_25MHz = ~clk_25MHz;
  always @(posedge clk_25MHz) cyc <= cyc + 1;

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_25MHz);
  endtask

  // Drive nbits of a frame; when chg is set, push the expected vector timed from the stop-bit fall
  task automatic send_frame(input logic [7:0] b, input int nbits, input logic bad_par,
                            input logic bad_stop, input logic chg, input logic [4:0] vec);
    logic [10:0] fr;
    exp_t e;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk_25MHz);
      PS2Data = fr[i];
      wait_cyc(HALF);
      PS2Clk = 1'b0;
      if (i == 10 && chg) begin
        e.vec = vec;
        e.cyc = cyc + LAT;
        chg_q.push_back(e);
      end
      wait_cyc(HALF);
      PS2Clk = 1'b1;
    end
    wait_cyc(HALF);
    PS2Data = 1'b1;
    wait_cyc(60);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 11, 1'b0, 1'b0, 1'b0, 5'b0);
  endtask

  task automatic send_chg(input logic [7:0] b, input logic [4:0] vec);
    send_frame(b, 11, 1'b0, 1'b0, 1'b1, vec);
  endtask

  task automatic checkpoint(input logic [4:0] vec);
    exp_t e;
    e.vec = vec;
    e.cyc = -1;
    chk_q.push_back(e);
    @(posedge clk_25MHz);
    chk_req = 1'b1;
    @(posedge clk_25MHz);
    chk_req = 1'b0;
  endtask

  // Monitor: compares every output change and every checkpoint against the scoreboard
  initial begin : monitor
    logic [4:0] prev, cur;
    exp_t e;
    prev = 5'b0;
    forever begin
      @(negedge clk_25MHz);
      if (mon_en) begin
        cur = {upKeyState, downKeyState, leftKeyState, rightKeyState, spaceKeyState};
        if (cur !== prev) begin
          n_cmp++;
          if (chg_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_change at cycle %0d: got %b, had %b", cyc, cur, prev);
          end else begin
            e = chg_q.pop_front();
            if (cur !== e.vec || (e.cyc >= 0 && cyc != e.cyc)) begin
              n_err++;
              $display("FAIL change: got %b at cycle %0d, want %b at cycle %0d", cur, cyc, e.vec, e.cyc);
            end
          end
          prev = cur;
        end
        if (chk_req) begin
          n_cmp++;
          if (chk_q.size() == 0) begin
            n_err++;
            $display("FAIL checkpoint: no expectation queued, got %b", cur);
          end else begin
            e = chk_q.pop_front();
            if (cur !== e.vec) begin
              n_err++;
              $display("FAIL checkpoint at cycle %0d: got %b, want %b", cyc, cur, e.vec);
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #(100000 * 40);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Vectors are {up, down, left, right, space}
  initial begin : stimulus
    #1 rst = 1'b1;
    wait_cyc(5);
    mon_en = 1'b1;
    checkpoint(5'b00000);               // reset state
    @(negedge clk_25MHz);
    rst = 1'b0;
    wait_cyc(20);

    // Up make/break with exact latency
    send(8'hE0); send_chg(8'h75, 5'b10000);
    checkpoint(5'b10000);
    send(8'hE0); send(8'hF0); send_chg(8'h75, 5'b00000);
    checkpoint(5'b00000);

    // Space with simultaneous arrows, then independent releases
    send_chg(8'h29, 5'b00001);
    send(8'hE0); send_chg(8'h6B, 5'b00101);
    send(8'hE0); send_chg(8'h74, 5'b00111);
    checkpoint(5'b00111);
    send(8'hF0); send_chg(8'h29, 5'b00110);
    checkpoint(5'b00110);
    send(8'hE0); send(8'h74);           // typematic repeat: no change
    send(8'hE0); send(8'hF0); send_chg(8'h6B, 5'b00010);
    send(8'hE0); send(8'hF0); send_chg(8'h74, 5'b00000);

    // Bad parity, then bad stop bit: dropped; a good 29 still works
    send_frame(8'h29, 11, 1'b1, 1'b0, 1'b0, 5'b0);
    send_frame(8'h29, 11, 1'b0, 1'b1, 1'b0, 5'b0);
    checkpoint(5'b00000);
    send_chg(8'h29, 5'b00001);
    send(8'hF0); send_chg(8'h29, 5'b00000);

    // Keypad and ignored codes; flags must be clear afterwards
    send(8'h75);
    checkpoint(5'b00000);
    send(8'hE0); send(8'h29);
    checkpoint(5'b00000);
    send(8'hE0); send(8'h1C);
    send(8'h75);                        // ext cleared, so still keypad
    checkpoint(5'b00000);
    send(8'hF0); send(8'h1C);
    send_chg(8'h29, 5'b00001);          // brk cleared, so this is a make
    send(8'hF0); send_chg(8'h29, 5'b00000);

    // Partial frame then idle past timeout: no misalignment afterwards
    send_frame(8'hE0, 5, 1'b0, 1'b0, 1'b0, 5'b0);
    wait_cyc(TMO + 1000);
    send(8'hE0); send_chg(8'h72, 5'b01000);
    checkpoint(5'b01000);

    // Short PS2Clk glitch with data low must not start a frame
    @(negedge clk_25MHz);
    PS2Data = 1'b0;
    wait_cyc(5);
    PS2Clk = 1'b0;
    wait_cyc(3);
    PS2Clk = 1'b1;
    wait_cyc(20);
    PS2Data = 1'b1;
    wait_cyc(100);
    send(8'hE0); send(8'hF0); send_chg(8'h72, 5'b00000);

    // Reset mid-frame with Down and Right held
    send(8'hE0); send_chg(8'h72, 5'b01000);
    send(8'hE0); send_chg(8'h74, 5'b01010);
    send_frame(8'hE0, 6, 1'b0, 1'b0, 1'b0, 5'b0);
    begin
      exp_t e;
      e.vec = 5'b00000;
      e.cyc = -1;
      chg_q.push_back(e);
    end
    @(negedge clk_25MHz);
    PS2Clk = 1'b0;                      // mid-bit when reset hits
    wait_cyc(10);
    rst = 1'b1;
    wait_cyc(3);
    checkpoint(5'b00000);
    PS2Clk = 1'b1;
    wait_cyc(5);
    rst = 1'b0;
    wait_cyc(20);
    send(8'hE0); send_chg(8'h74, 5'b00010);
    checkpoint(5'b00010);

    wait_cyc(50);
    n_cmp++;
    if (chg_q.size() != 0) begin
      n_err++;
      $display("FAIL pending_changes: %0d expected changes never seen, want 0", chg_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/keyboard.md
# keyboard

PS/2 keyboard receiver and key-state tracker for the game input path. It takes the raw PS/2 clock and data lines, deframes scan-code set 2 bytes, and holds a level-valued pressed/released flag for five game keys: Up, Down, Left, Right and Space. It sits between the board PS/2 pins and the movement logic, which reads the five flags as a 5-bit move state.

## Interface
- `FILTER_LEN`, default 8: number of consecutive identical `clk_25MHz` samples required before the filtered PS2Clk changes level.
- `TIMEOUT_CYCLES`, default 50000: idle `clk_25MHz` cycles (2 ms) after which a partially received frame is discarded.
- `clk_25MHz`  in  1  system clock, 25 MHz; the only clock in the block.
- `rst`  in  1  asynchronous, active-high reset.
- `PS2Clk`  in  1  raw PS/2 clock from the keyboard; asynchronous to `clk_25MHz`.
- `PS2Data`  in  1  raw PS/2 data from the keyboard; asynchronous to `clk_25MHz`.
- `upKeyState`  out  1  1 while Up arrow is held.
- `downKeyState`  out  1  1 while Down arrow is held.
- `leftKeyState`  out  1  1 while Left arrow is held.
- `rightKeyState`  out  1  1 while Right arrow is held.
- `spaceKeyState`  out  1  1 while Space is held.

## Operation
- **Input conditioning**
  - `PS2Clk` and `PS2Data` each pass through a 2-flop synchronizer.
  - The synchronized clock passes through a `FILTER_LEN` glitch filter.
  - A sampling event is one cycle in which the filtered clock goes from 1 to 0.
  - `PS2Data` is sampled from its synchronizer on that event.
- **Frame receiver**: 11 bits per frame, in this order:
  - start bit, must be 0;
  - 8 data bits, LSB first;
  - odd parity bit;
  - stop bit, must be 1.
- **Bad frames**
  - A frame with a bad start bit, bad parity or bad stop bit is dropped silently.
  - The bit counter then returns to idle.
- **Timeout**: if `TIMEOUT_CYCLES` cycles pass with no falling edge while mid-frame, the counter resets to idle and the partial data is dropped.
- **Decoder flags**: sticky flags `ext` and `brk` track prefix bytes.
  - Byte E0: set `ext`.
  - Byte F0: set `brk`.
  - Any other byte is a key code. It is acted on, then both flags are cleared.
- **Key-code mapping**, where "value" is 1 when `brk` is 0 and 0 when `brk` is 1:
  - `ext`=1 with code 75: `upKeyState` = value.
  - `ext`=1 with code 72: `downKeyState` = value.
  - `ext`=1 with code 6B: `leftKeyState` = value.
  - `ext`=1 with code 74: `rightKeyState` = value.
  - `ext`=0 with code 29: `spaceKeyState` = value.
- **Ignored codes**
  - Codes 75, 72, 6B and 74 without E0 (keypad keys) are ignored.
  - Code 29 with E0 is ignored.
  - All other codes are ignored, but they still clear the flags.
- **Independence**: each output changes only on its own make or break code. Any combination of keys may be held at the same time. Typematic repeats of a make code leave the output at 1.
- **Dropped frames**
  - A dropped frame does not change the prefix flags.
  - A dropped frame does not change any output.
- Glitches shorter than `FILTER_LEN` cycles on PS2Clk produce no sampling event.

## Timing
- **Reset**: asserting `rst` clears all five outputs to 0. It also clears:
  - the bit counter, shift register, `ext`, `brk` and timeout counter;
  - the synchronizers and filter, which reset to 1 (idle bus).
- **Reset mid-frame**: the partial frame is lost, and reception restarts at the next start bit after `rst` deasserts.
- **Output latency**: an output updates exactly 1 `clk_25MHz` cycle after the sampling event that captures a valid stop bit of a key-code byte.
- **Input delay**: from a raw PS2Clk falling edge to the sampling event takes 2 synchronizer cycles plus `FILTER_LEN` cycles.
- **Outputs** are registered and glitch-free. They hold their value until the matching break code or reset.
- **Output-only**: the block never drives PS2Clk or PS2Data; there is no host-to-device path.
- **PS/2 bit clock**: 10–16.7 kHz, i.e. at least 1500 `clk_25MHz` cycles per bit, far above `FILTER_LEN`.

## Test plan
- **Up make**: send frames E0, 75 → `upKeyState` goes 0→1 one cycle after the stop bit of 75; other outputs stay 0. Then send E0, F0, 75 → `upKeyState` goes to 0.
- **Space with simultaneous arrows**: send 29, then E0 6B, then E0 74 → space, left and right all read 1. Send F0 29 → only `spaceKeyState` clears.
- **Bad frames**: send 29 with wrong parity, then a frame with stop bit 0 → all outputs stay 0. A following valid 29 sets `spaceKeyState`.
- **Keypad and ignored codes**: send 75 without E0 → `upKeyState` stays 0. Send E0 29 → `spaceKeyState` stays 0. Send E0 1C → no output changes, and the flags are clear afterwards.
- **Timeout and glitch**: send 5 bits, idle 60000 cycles, then send a full 72 after E0 → `downKeyState` = 1 (no misalignment). A 3-cycle low pulse on PS2Clk → no bit is captured.
- **Reset mid-operation**: hold Down and Right at 1, assert `rst` mid-frame → all outputs 0 immediately. After release, E0 74 → `rightKeyState` = 1.
